// File: rtl/cp_l2mem_requester.sv
// Per-CP block-transfer initiator for the shared L2 data memory (L2<->local DMEM).
// Define CP_L2REQ_WAITCNT_EN to build the saturating grant-wait cycle counter.
module cp_l2mem_requester #(
  parameter int CP_D_WIDTH      = 72,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int LOC_ADDR_WIDTH  = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic [DMEM_ADDR_WIDTH-1:0] cmd_l2_addr,
  input  logic [LOC_ADDR_WIDTH-1:0]  cmd_loc_addr,
  input  logic [DMEM_ADDR_WIDTH:0]   cmd_len,
  output logic                       busy,
  output logic                       done,
  output logic                       trq,
  input  logic                       tack,
  output logic [DMEM_ADDR_WIDTH-1:0] l2_addr,
  output logic [CP_D_WIDTH-1:0]      l2_in,
  output logic                       l2_we,
  input  logic [CP_D_WIDTH-1:0]      dmem_l2_out,
  output logic [LOC_ADDR_WIDTH-1:0]  loc_addr,
  output logic [CP_D_WIDTH-1:0]      loc_din,
  output logic                       loc_we,
  input  logic [CP_D_WIDTH-1:0]      loc_dout,
  output logic [31:0]                wait_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  localparam logic [DMEM_ADDR_WIDTH:0]   BEAT_ONE = 1;
  localparam logic [DMEM_ADDR_WIDTH-1:0] L2_ONE   = 1;
  localparam logic [LOC_ADDR_WIDTH-1:0]  LOC_ONE  = 1;

  state_t                     state;
  logic                       dir_q;
  logic [DMEM_ADDR_WIDTH:0]   len_q;
  logic [DMEM_ADDR_WIDTH:0]   beat;
  logic [DMEM_ADDR_WIDTH-1:0] l2_ptr;
  logic [LOC_ADDR_WIDTH-1:0]  loc_ptr;
  logic                       issued_q;
  logic [CP_D_WIDTH-1:0]      hold_q;

  logic                  adv;
  logic                  issue;
  logic                  wr_beat;
  logic [CP_D_WIDTH-1:0] live_data;
  logic [CP_D_WIDTH-1:0] wr_data;

  // Beat k issues a read on the source side; the following advancing beat writes it.
  // Read data arrives exactly one cycle after an issue; if the grant is gone by then
  // it is parked in hold_q until tack returns.
  assign adv       = (state == XFER) && tack;
  assign issue     = adv && (beat != len_q);
  assign wr_beat   = adv && (beat != '0);
  assign live_data = dir_q ? loc_dout : dmem_l2_out;
  assign wr_data   = issued_q ? live_data : hold_q;

  assign l2_we    = wr_beat && dir_q;
  assign loc_we   = wr_beat && !dir_q;
  assign l2_in    = dir_q ? wr_data : '0;
  assign loc_din  = dir_q ? '0 : wr_data;
  assign l2_addr  = l2_ptr;
  assign loc_addr = loc_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      len_q     <= '0;
      beat      <= '0;
      l2_ptr    <= '0;
      loc_ptr   <= '0;
      issued_q  <= 1'b0;
      hold_q    <= '0;
      trq       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      issued_q <= issue;
      if (issued_q && !tack)
        hold_q <= live_data;
      if (adv)
        beat <= beat + BEAT_ONE;
      if (dir_q) begin
        if (issue)   loc_ptr <= loc_ptr + LOC_ONE;
        if (wr_beat) l2_ptr  <= l2_ptr + L2_ONE;
      end else begin
        if (issue)   l2_ptr  <= l2_ptr + L2_ONE;
        if (wr_beat) loc_ptr <= loc_ptr + LOC_ONE;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            len_q     <= cmd_len;
            beat      <= '0;
            l2_ptr    <= cmd_l2_addr;
            loc_ptr   <= cmd_loc_addr;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            // An empty block never bothers the arbiter.
            if (cmd_len == '0) begin
              state <= REL;
              done  <= 1'b1;
            end else begin
              state <= REQ;
              trq   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (tack)
            state <= XFER;
        end
        XFER: begin
          if (adv && (beat == len_q)) begin
            state <= REL;
            trq   <= 1'b0;
            done  <= 1'b1;
          end
        end
        REL: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CP_L2REQ_WAITCNT_EN
  logic [31:0] wait_q;

  // Counts every cycle spent asking for the grant, saturating rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset)
      wait_q <= '0;
    else if (((state == REQ) || ((state == XFER) && !tack)) && (wait_q != '1))
      wait_q <= wait_q + 32'd1;
  end

  assign wait_cnt = wait_q;
`else
  assign wait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cp_l2mem_requester.sv
// Directed bench for cp_l2mem_requester: arbiter/memory models plus a write scoreboard.
module tb_cp_l2mem_requester;

  localparam int W  = 72;
  localparam int AW = 10;
  localparam int LW = 10;
`ifdef CP_L2REQ_WAITCNT_EN
  localparam int WAIT_EN = 1;
`else
  localparam int WAIT_EN = 0;
`endif
  localparam logic [W-1:0] GARBAGE = 72'hEE_DEADBEEF_BADC0FFE;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [AW-1:0] cmd_l2_addr;
  logic [LW-1:0] cmd_loc_addr;
  logic [AW:0]   cmd_len;
  logic          busy;
  logic          done;
  logic          trq;
  logic          tack;
  logic [AW-1:0] l2_addr;
  logic [W-1:0]  l2_in;
  logic          l2_we;
  logic [W-1:0]  dmem_l2_out;
  logic [LW-1:0] loc_addr;
  logic [W-1:0]  loc_din;
  logic          loc_we;
  logic [W-1:0]  loc_dout;
  logic [31:0]   wait_cnt;

  cp_l2mem_requester dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_l2_addr(cmd_l2_addr), .cmd_loc_addr(cmd_loc_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .trq(trq), .tack(tack),
    .l2_addr(l2_addr), .l2_in(l2_in), .l2_we(l2_we), .dmem_l2_out(dmem_l2_out),
    .loc_addr(loc_addr), .loc_din(loc_din), .loc_we(loc_we), .loc_dout(loc_dout),
    .wait_cnt(wait_cnt)
  );

  typedef struct {
    logic [9:0]   addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t          loc_q[$];
  wr_t          l2_q[$];
  logic [W-1:0] l2mem  [1024];
  logic [W-1:0] locmem [1024];

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int hold_off = 0;
  int stall_start = 1000000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arbiter: grants one cycle after it sees trq, once trq has been pending hold_off
  // cycles, and withdraws the grant for 3 cycles starting at age stall_start.
  initial begin
    int age;
    logic nt;
    tack = 1'b0;
    age  = 0;
    forever begin
      @(negedge clock);
      nt  = trq && (age >= hold_off) && !((age >= stall_start) && (age < stall_start + 3));
      age = trq ? age + 1 : 0;
      @(posedge clock);
      #1 tack = nt;
    end
  end

  // L2 returns data one cycle later only if it was granted; local DMEM always does.
  initial begin
    logic [AW-1:0] l2a;
    logic [LW-1:0] la;
    logic          t;
    dmem_l2_out = '0;
    loc_dout    = '0;
    forever begin
      @(negedge clock);
      l2a = l2_addr;
      la  = loc_addr;
      t   = tack;
      if (l2_we && tack) l2mem[l2_addr] = l2_in;
      if (loc_we) locmem[loc_addr] = loc_din;
      @(posedge clock);
      #1;
      dmem_l2_out = t ? l2mem[l2a] : GARBAGE;
      loc_dout    = locmem[la];
    end
  end

  // Scoreboard monitor: every write the DUT presents is matched in order.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (done) done_count++;
      if (loc_we) begin
        checks++;
        if (!tack) begin
          errors++;
          $display("[TB] FAIL loc_write_no_grant: addr=%h while tack=0", loc_addr);
        end else if (loc_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL loc_write_unexpected: addr=%h data=%h", loc_addr, loc_din);
        end else begin
          e = loc_q.pop_front();
          if (loc_addr !== e.addr || loc_din !== e.data) begin
            errors++;
            $display("[TB] FAIL loc_write: got addr=%h data=%h expected addr=%h data=%h",
                     loc_addr, loc_din, e.addr, e.data);
          end
        end
      end
      if (l2_we) begin
        checks++;
        if (!tack) begin
          errors++;
          $display("[TB] FAIL l2_write_no_grant: addr=%h while tack=0", l2_addr);
        end else if (l2_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL l2_write_unexpected: addr=%h data=%h", l2_addr, l2_in);
        end else begin
          e = l2_q.pop_front();
          if (l2_addr !== e.addr || l2_in !== e.data) begin
            errors++;
            $display("[TB] FAIL l2_write: got addr=%h data=%h expected addr=%h data=%h",
                     l2_addr, l2_in, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queues the expected writes for the first nexp words, then offers the command
  // for one cycle; on return the DUT has just accepted it (cycle T has ended).
  task automatic applyStimulus(input logic dir, input logic [9:0] a, input logic [9:0] b,
                               input int n, input int nexp);
    wr_t e;
    for (int k = 0; k < nexp; k++) begin
      if (dir) begin
        e.addr = 10'(a + 10'(k));
        e.data = locmem[10'(b + 10'(k))];
        l2_q.push_back(e);
      end else begin
        e.addr = 10'(b + 10'(k));
        e.data = l2mem[10'(a + 10'(k))];
        loc_q.push_back(e);
      end
    end
    @(negedge clock);
    cmd_valid    = 1'b1;
    cmd_dir      = dir;
    cmd_l2_addr  = a;
    cmd_loc_addr = b;
    cmd_len      = 11'(n);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic traceCycles(input int n, output logic [63:0] trq_bits, output logic [63:0] done_bits);
    trq_bits  = '0;
    done_bits = '0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clock);
      trq_bits[j]  = trq;
      done_bits[j] = done;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] tb;
    logic [63:0] db;
    logic [31:0] w0;
    int          d0;

    for (int i = 0; i < 1024; i++) begin
      l2mem[i]  = {8'hC3, 32'(i), ~32'(i)};
      locmem[i] = {8'h3C, 32'(i * 7 + 1), 32'(i)};
    end
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_l2_addr = '0; cmd_loc_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_ctrl", {58'd0, trq, l2_we, loc_we, done, busy, cmd_ready}, 64'h1);
    checkOutput("reset_wait", 64'(wait_cnt), 64'd0);
    checkOutput("reset_addr", {44'd0, l2_addr, loc_addr}, 64'd0);
    checkOutput("reset_data", 64'(l2_in | loc_din), 64'd0);
    reset = 1'b0;

    $display("[TB] read N=4 A=010 B=020, idle arbiter");
    w0 = wait_cnt;
    applyStimulus(1'b0, 10'h010, 10'h020, 4, 4);
    traceCycles(12, tb, db);
    checkOutput("t1_trq", tb, 64'h0FE);
    checkOutput("t1_done", db, 64'h100);
    checkOutput("t1_drain", 64'(loc_q.size()), 64'd0);
    checkOutput("t1_wait", 64'(wait_cnt - w0), 64'(WAIT_EN * 2));

    $display("[TB] write N=3 A=3FE B=005 with wrap, stray cmd_valid while busy");
    d0 = done_count;
    applyStimulus(1'b1, 10'h3FE, 10'h005, 3, 3);
    @(negedge clock);
    checkOutput("t2_busy", {62'd0, busy, cmd_ready}, 64'h2);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 11'd5;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("t2_drain", 64'(l2_q.size() + loc_q.size()), 64'd0);
    checkOutput("t2_done_once", 64'(done_count - d0), 64'd1);

    $display("[TB] empty block N=0");
    applyStimulus(1'b0, 10'h123, 10'h045, 0, 0);
    traceCycles(6, tb, db);
    checkOutput("t3_no_trq", tb, 64'd0);
    checkOutput("t3_done_once", 64'($countones(db)), 64'd1);
    checkOutput("t3_ready", 64'(cmd_ready), 64'd1);

    $display("[TB] read N=2 with arbiter busy for 20 cycles");
    hold_off = 19;
    w0 = wait_cnt;
    applyStimulus(1'b0, 10'h100, 10'h200, 2, 2);
    traceCycles(30, tb, db);
    hold_off = 0;
    checkOutput("t4_trq", tb, 64'h1FFFFFE);
    checkOutput("t4_done", db, 64'h2000000);
    checkOutput("t4_drain", 64'(loc_q.size()), 64'd0);
    checkOutput("t4_wait", 64'(wait_cnt - w0), 64'(WAIT_EN * 21));

    $display("[TB] read N=8 with a 3-cycle grant drop mid-transfer");
    stall_start = 4;
    w0 = wait_cnt;
    applyStimulus(1'b0, 10'h040, 10'h300, 8, 8);
    traceCycles(20, tb, db);
    stall_start = 1000000;
    checkOutput("t5_trq", tb, 64'h7FFE);
    checkOutput("t5_done", db, 64'h8000);
    checkOutput("t5_drain", 64'(loc_q.size()), 64'd0);
    checkOutput("t5_wait", 64'(wait_cnt - w0), 64'(WAIT_EN * 5));

    $display("[TB] reset pulsed in third transfer cycle");
    applyStimulus(1'b0, 10'h0A0, 10'h0B0, 6, 2);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("t6_ctrl", {60'd0, trq, busy, cmd_ready, done}, 64'h2);
    checkOutput("t6_wait", 64'(wait_cnt), 64'd0);
    repeat (8) @(negedge clock);
    checkOutput("t6_partial", 64'(loc_q.size()), 64'd0);
    checkOutput("t6_idle", {62'd0, trq, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
